jp_emu: RTL
===========

# jp_emu

Joypad responder that emulates two standard NES controllers on the console's joypad port. It samples the console-driven joypad clock and latch lines and serially returns button state on two data lines, as a 4021 shift register would. It sits at the controller end of the same clock/latch/data protocol the RP2A03 joypad controller initiates, and is used for bench loopback and for host-injected input.

## Interface

**Parameters**
- FILTER_CYCLES, default 4: consecutive clocks a synchronized line must differ from its filtered level before the filtered level changes. Legal range is 1..15.

**Ports**
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous reset, active-high.
- btn1_in, input, 8: pad 1 buttons, 1 = pressed. Bit 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- btn2_in, input, 8: pad 2 buttons, same encoding.
- btn_upd_in, input, 1: single-cycle pulse that captures btn1_in/btn2_in into the pending registers.
- jp_clk_in, input, 1: joypad clock from the console. Asynchronous.
- jp_latch_in, input, 1: joypad latch from the console, active-high. Asynchronous.
- jp_data1_out, output, 1: pad 1 serial data, active-low (pressed = 0).
- jp_data2_out, output, 1: pad 2 serial data, active-low.
- latch_cnt_out, output, 8: count of accepted latch rising edges. Wraps.

One clock; reset is synchronous and active-high.

## Operation

**Input conditioning**
- jp_clk_in and jp_latch_in each pass through a 2-flop synchronizer (s1, s2), then a filter.
- Each filter has a 4-bit counter:
  - s2 == filtered level: counter is cleared.
  - Otherwise the counter increments. When the counter equals FILTER_CYCLES-1 while s2 still differs, the filtered level takes s2 and the counter clears.

**Pending buttons**
- btn_upd_in = 1 copies btn1_in/btn2_in into pend1/pend2 at that edge.
- pend1/pend2 hold their value otherwise.

**State machine** (states: IDLE, LOAD, SHIFT, EMPTY)
- IDLE (reset state): outputs are 1. A filtered latch rise goes to LOAD.
- LOAD (filtered latch high):
  - Every cycle, sr1 <= pend1, sr2 <= pend2, and bit index <= 0.
  - Filtered clk edges are ignored.
  - Filtered latch fall goes to SHIFT.
- SHIFT:
  - Each filtered clk rising edge shifts sr1/sr2 right, filling bit 7 with 1, and increments the index.
  - When index reaches 8, go to EMPTY.
- EMPTY: the shift registers contain all 1s, so the outputs are held at 0. Further clk edges change nothing.
- From SHIFT or EMPTY, a filtered latch rise goes to LOAD.

**Outputs and counter**
- jp_dataN_out is a registered copy of ~srN[0] in LOAD, SHIFT and EMPTY, and 1 in IDLE.
- latch_cnt_out increments on every filtered latch rising edge. 255 wraps to 0.

**Boundary conditions**
- btn_upd_in while in LOAD: the new value is captured into pend at edge t, reaches sr at edge t+1, and reaches the output at t+2.
- btn_upd_in in SHIFT or EMPTY: does not disturb the serial stream in progress. The new value takes effect at the next latch.
- Filtered latch rise and filtered clk rise in the same cycle: the latch takes priority; the clk edge is discarded.
- Reset mid-transfer:
  - State goes to IDLE; pend, sr, index, filters, synchronizers and latch_cnt_out are cleared.
  - Outputs go to 1 at the next edge.

## Timing

- Reset values: jp_data1_out = 1, jp_data2_out = 1, latch_cnt_out = 0.
- Pin-to-output latency: for a raw pin edge sampled at edge t, the filtered level changes at t+1+FILTER_CYCLES and the data outputs update at t+2+FILTER_CYCLES. With the default FILTER_CYCLES = 4 this is 6 cycles.
- Glitch rejection: a pulse shorter than FILTER_CYCLES clocks (as seen at s2) is rejected.
- latch_cnt_out updates in the same cycle the filtered latch rises.
- Minimum accepted high or low phase of jp_clk_in and jp_latch_in: FILTER_CYCLES clocks.

## Test plan

- **Reset values:** assert rst_in for 2 cycles -> jp_data1_out = 1, jp_data2_out = 1, latch_cnt_out = 0.
- **Full read, default filter:**
  - Stimulus: btn1 = 0x09 and btn2 = 0x80 loaded via btn_upd_in; latch high then low for 20 clocks each; 8 clk pulses, each 20 clocks high and 20 clocks low.
  - pad 1 bits, sampled before each clk rise (A first): 0,1,1,0,1,1,1,1.
  - pad 2 bits: 1,1,1,1,1,1,1,0.
  - After a 9th clk pulse, both outputs are 0.
  - latch_cnt_out = 1.
- **Glitch rejection:** with FILTER_CYCLES = 4, drive a 3-cycle pulse on jp_clk_in during SHIFT -> no shift and no output change. A 4-cycle pulse -> one shift.
- **Update collisions:**
  - btn_upd_in with btn1 = 0x01 while in LOAD, previous value 0x00 -> jp_data1_out goes to 0 two cycles after the pulse.
  - The same update during SHIFT -> the current stream is unchanged.
- **Latch priority and wrap:** raise latch and clk simultaneously in SHIFT -> re-enters LOAD and the index resets. 256 latch pulses -> latch_cnt_out = 0.
- **Reset mid-transfer:** assert rst_in after 3 shifts -> IDLE, outputs 1. The next latch/read sequence returns 0x00, i.e. all outputs 1 until EMPTY, since pend was cleared.

Source files
------------

// File: rtl/jp_emu.sv
// jp_emu: two-pad NES controller emulator on the console joypad port.
// Filtered clk/latch lines drive a 4021-style serial responder.

module jp_emu_filt #(
   parameter int FILTER_CYCLES = 4
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic pin,
   output logic lvl,
   output logic flip
);

   localparam logic [3:0] LIM = 4'(FILTER_CYCLES - 1);

   logic       s1;
   logic       s2;
   logic [3:0] cnt;

   // flip marks the cycle whose edge moves lvl to s2
   assign flip = (s2 != lvl) && (cnt == LIM);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         lvl <= 1'b0;
         cnt <= 4'd0;
      end else begin
         s1 <= pin;
         s2 <= s1;
         if (s2 == lvl) begin
            cnt <= 4'd0;
         end else if (flip) begin
            lvl <= s2;
            cnt <= 4'd0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

endmodule

module jp_emu #(
   parameter int FILTER_CYCLES = 4
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] btn1_in,
   input  logic [7:0] btn2_in,
   input  logic       btn_upd_in,
   input  logic       jp_clk_in,
   input  logic       jp_latch_in,
   output logic       jp_data1_out,
   output logic       jp_data2_out,
   output logic [7:0] latch_cnt_out
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      EMPTY
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       clk_lvl;
   logic       clk_flip;
   logic       lat_lvl;
   logic       lat_flip;
   logic       clk_rise;
   logic       lat_rise;
   logic       lat_fall;
   logic [7:0] pend1;
   logic [7:0] pend2;
   logic [7:0] sr1;
   logic [7:0] sr2;
   logic [3:0] idx;

   jp_emu_filt #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .pin    (jp_clk_in),
      .lvl    (clk_lvl),
      .flip   (clk_flip)
   );

   jp_emu_filt #(.FILTER_CYCLES(FILTER_CYCLES)) u_lat_filt (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .pin    (jp_latch_in),
      .lvl    (lat_lvl),
      .flip   (lat_flip)
   );

   // edges are seen in the same cycle the filtered level moves
   assign clk_rise = clk_flip & ~clk_lvl;
   assign lat_rise = lat_flip & ~lat_lvl;
   assign lat_fall = lat_flip &  lat_lvl;

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (lat_rise) state_nxt = LOAD;
         LOAD:  if (lat_fall) state_nxt = SHIFT;
         SHIFT: begin
            if (lat_rise)
               state_nxt = LOAD;
            else if (clk_rise && idx == 4'd7)
               state_nxt = EMPTY;
         end
         EMPTY: if (lat_rise) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pend1         <= 8'h00;
         pend2         <= 8'h00;
         sr1           <= 8'h00;
         sr2           <= 8'h00;
         idx           <= 4'd0;
         jp_data1_out  <= 1'b1;
         jp_data2_out  <= 1'b1;
         latch_cnt_out <= 8'h00;
      end else begin
         if (btn_upd_in) begin
            pend1 <= btn1_in;
            pend2 <= btn2_in;
         end
         // latch wins over a coincident clk edge
         if (state == LOAD || lat_rise) begin
            sr1 <= pend1;
            sr2 <= pend2;
            idx <= 4'd0;
         end else if (state == SHIFT && clk_rise) begin
            sr1 <= {1'b1, sr1[7:1]};
            sr2 <= {1'b1, sr2[7:1]};
            idx <= idx + 4'd1;
         end
         if (lat_rise)
            latch_cnt_out <= latch_cnt_out + 8'd1;
         if (state == IDLE) begin
            jp_data1_out <= 1'b1;
            jp_data2_out <= 1'b1;
         end else begin
            jp_data1_out <= ~sr1[0];
            jp_data2_out <= ~sr2[0];
         end
      end
   end

endmodule
